frame_gen: RTL and testbench

- Initiator-side frame transmitter for the multiboot UART flash-update link; mirror of the on-target frame receiver/controller.
- Builds and sends byte-serial command frames: 7×0x55 preamble, 0xD5 SFD, command byte, 3 address bytes, then payload for writes.
- Drives a UART TX byte interface, then watches the UART RX byte stream for the target's completion ack, with a timeout.
- Used on the host/bridge FPGA and in loopback benches against the target frame controller.

---
 rtl/frame_gen.sv | 270 +++++++++++++++++++++++++++
 tb/tb_frame_gen.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_gen.sv
// ---------------------------------------------------------------------------
// frame_gen
// Initiator-side command frame transmitter for the UART flash-update link.
// Sends 7x 0x55 preamble, 0xD5 SFD, command byte (0xAA write / 0x55 erase),
// three address bytes MSB first and, for writes, len payload bytes fetched
// through a data_req/data_in handshake. Then it waits for the target's ack
// byte on the UART RX stream, with a timeout.
//
// Ports:
//   sclk, rst            clock, asynchronous active-high reset
//   start                one-cycle frame request (accepted only in IDLE)
//   cmd_erase, addr, len frame parameters, latched with start
//   data_req / data_in   payload fetch; data_in valid one cycle after data_req
//   tx_data / tx_flag    byte and strobe to the UART transmitter
//   tx_done              UART transmitter finished shifting the byte out
//   rx_data / rx_flag    byte and strobe from the UART receiver
//   busy, done           transaction in progress / end-of-transaction pulse
//   ack_ok/err/tmo       held status of the last transaction
// ---------------------------------------------------------------------------
module frame_gen #(
   parameter int ACK_TIMEOUT = 2500000,
   parameter int CNT_W       = 32
) (
   input  logic        sclk,
   input  logic        rst,
   input  logic        start,
   input  logic        cmd_erase,
   input  logic [23:0] addr,
   input  logic [15:0] len,
   output logic        data_req,
   input  logic [7:0]  data_in,
   output logic [7:0]  tx_data,
   output logic        tx_flag,
   input  logic        tx_done,
   input  logic [7:0]  rx_data,
   input  logic        rx_flag,
   output logic        busy,
   output logic        done,
   output logic        ack_ok,
   output logic        ack_err,
   output logic        ack_tmo
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_SFD,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_WAIT_ACK
   } state_t;

   localparam logic [7:0]       PRE_BYTE  = 8'h55;
   localparam logic [7:0]       SFD_BYTE  = 8'hD5;
   localparam logic [7:0]       CMD_WRITE = 8'hAA;
   localparam logic [7:0]       CMD_ERASE = 8'h55;
   localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ACK_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic             erase_q, erase_d;
   logic [23:0]      addr_q, addr_d;
   logic [15:0]      lenCnt_q, lenCnt_d;
   logic [2:0]       preCnt_q, preCnt_d;
   logic [1:0]       addrIdx_q, addrIdx_d;
   logic [CNT_W-1:0] tmoCnt_q, tmoCnt_d;
   logic             waitTx_q, waitTx_d;
   logic             txFlag_q, txFlag_d;
   logic [7:0]       txData_q, txData_d;
   logic             dataReq_q, dataReq_d;
   logic             capPhase_q, capPhase_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ackOk_q, ackOk_d;
   logic             ackErr_q, ackErr_d;
   logic             ackTmo_q, ackTmo_d;

   logic             txFlagNow;
   logic             byteDone;
   logic [7:0]       ackByte;
   logic [CNT_W-1:0] tmoNext;

   // A payload byte is strobed combinationally in its capture cycle (the cycle
   // after data_req) so that payload bytes follow tx_done with only two cycles
   // of latency; every other byte is strobed from txFlag_q.
   assign txFlagNow = txFlag_q | capPhase_q;
   assign byteDone  = waitTx_q & tx_done;
   assign ackByte   = erase_q ? CMD_ERASE : CMD_WRITE;
   assign tmoNext   = tmoCnt_q + CNT_W'(1);

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         erase_q    <= 1'b0;
         addr_q     <= '0;
         lenCnt_q   <= '0;
         preCnt_q   <= '0;
         addrIdx_q  <= '0;
         tmoCnt_q   <= '0;
         waitTx_q   <= 1'b0;
         txFlag_q   <= 1'b0;
         txData_q   <= '0;
         dataReq_q  <= 1'b0;
         capPhase_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ackOk_q    <= 1'b0;
         ackErr_q   <= 1'b0;
         ackTmo_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         erase_q    <= erase_d;
         addr_q     <= addr_d;
         lenCnt_q   <= lenCnt_d;
         preCnt_q   <= preCnt_d;
         addrIdx_q  <= addrIdx_d;
         tmoCnt_q   <= tmoCnt_d;
         waitTx_q   <= waitTx_d;
         txFlag_q   <= txFlag_d;
         txData_q   <= txData_d;
         dataReq_q  <= dataReq_d;
         capPhase_q <= capPhase_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ackOk_q    <= ackOk_d;
         ackErr_q   <= ackErr_d;
         ackTmo_q   <= ackTmo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      erase_d    = erase_q;
      addr_d     = addr_q;
      lenCnt_d   = lenCnt_q;
      preCnt_d   = preCnt_q;
      addrIdx_d  = addrIdx_q;
      tmoCnt_d   = tmoCnt_q;
      waitTx_d   = waitTx_q;
      txFlag_d   = 1'b0;
      txData_d   = txData_q;
      dataReq_d  = 1'b0;
      capPhase_d = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      ackOk_d    = ackOk_q;
      ackErr_d   = ackErr_q;
      ackTmo_d   = ackTmo_q;

      // One byte outstanding: armed by the strobe, released by tx_done.
      if (txFlagNow) waitTx_d = 1'b1;
      if (byteDone)  waitTx_d = 1'b0;
      if (capPhase_q) txData_d = data_in;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               erase_d   = cmd_erase;
               addr_d    = addr;
               lenCnt_d  = len;
               preCnt_d  = '0;
               addrIdx_d = '0;
               tmoCnt_d  = '0;
               ackOk_d   = 1'b0;
               ackErr_d  = 1'b0;
               ackTmo_d  = 1'b0;
               busy_d    = 1'b1;
               txFlag_d  = 1'b1;
               txData_d  = PRE_BYTE;
               state_d   = ST_PRE;
            end
         end
         ST_PRE: begin
            if (byteDone) begin
               txFlag_d = 1'b1;
               if (preCnt_q == 3'd6) begin
                  txData_d = SFD_BYTE;
                  state_d  = ST_SFD;
               end else begin
                  preCnt_d = preCnt_q + 3'd1;
                  txData_d = PRE_BYTE;
               end
            end
         end
         ST_SFD: begin
            if (byteDone) begin
               txFlag_d = 1'b1;
               txData_d = ackByte;
               state_d  = ST_CMD;
            end
         end
         ST_CMD: begin
            if (byteDone) begin
               txFlag_d  = 1'b1;
               txData_d  = addr_q[23:16];
               addrIdx_d = 2'd0;
               state_d   = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (byteDone) begin
               case (addrIdx_q)
                  2'd0: begin
                     txFlag_d  = 1'b1;
                     txData_d  = addr_q[15:8];
                     addrIdx_d = 2'd1;
                  end
                  2'd1: begin
                     txFlag_d  = 1'b1;
                     txData_d  = addr_q[7:0];
                     addrIdx_d = 2'd2;
                  end
                  default: begin
                     if (!erase_q && (lenCnt_q != 16'd0)) begin
                        dataReq_d = 1'b1;
                        state_d   = ST_DATA;
                     end else begin
                        tmoCnt_d = '0;
                        state_d  = ST_WAIT_ACK;
                     end
                  end
               endcase
            end
         end
         ST_DATA: begin
            capPhase_d = dataReq_q;
            if (byteDone) begin
               lenCnt_d = lenCnt_q - 16'd1;
               if (lenCnt_q == 16'd1) begin
                  tmoCnt_d = '0;
                  state_d  = ST_WAIT_ACK;
               end else begin
                  dataReq_d = 1'b1;
               end
            end
         end
         ST_WAIT_ACK: begin
            // A received byte takes priority over a timeout in the same cycle.
            if (rx_flag) begin
               ackOk_d  = (rx_data == ackByte);
               ackErr_d = (rx_data != ackByte);
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = ST_IDLE;
            end else if (tmoNext == TMO_LAST) begin
               tmoCnt_d = tmoNext;
               ackTmo_d = 1'b1;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               tmoCnt_d = tmoNext;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_flag  = txFlagNow;
      tx_data  = capPhase_q ? data_in : txData_q;
      data_req = dataReq_q;
      busy     = busy_q;
      done     = done_q;
      ack_ok   = ackOk_q;
      ack_err  = ackErr_q;
      ack_tmo  = ackTmo_q;
   end

endmodule

// File: tb/tb_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_frame_gen
// Directed bench for frame_gen. Two instances share all inputs: dutS uses a
// 100-cycle ack timeout, dutL a 2000-cycle one for the slow-ack erase frame.
// useL routes start/rx_flag to one instance and selects whose outputs the
// UART/payload model and the checks look at.
// ---------------------------------------------------------------------------
module tb_frame_gen;

   typedef struct {
      bit          useL;
      bit          erase;
      logic [23:0] addr;
      logic [15:0] len;
      logic [7:0]  payBase;
      bit          rxEn;
      int          ackDelay;
      logic [7:0]  ackByte;
      int          restartAt;
      logic [2:0]  expStat;
      int          expReq;
      int          expGap;
   } vec_t;

   typedef logic [7:0] byteQ_t [$];

   logic        sclk      = 1'b0;
   logic        rst       = 1'b1;
   logic        start     = 1'b0;
   logic        cmd_erase = 1'b0;
   logic [23:0] addr      = '0;
   logic [15:0] len       = '0;
   logic [7:0]  data_in   = '0;
   logic        tx_done   = 1'b0;
   logic [7:0]  rx_data   = '0;
   logic        rx_flag   = 1'b0;
   logic        useL      = 1'b0;

   logic        startS, startL, rxFlagS, rxFlagL;
   logic        dataReqS, txFlagS, busyS, doneS, okS, errS, tmoS;
   logic        dataReqL, txFlagL, busyL, doneL, okL, errL, tmoL;
   logic [7:0]  txDataS, txDataL;

   logic        dataReqM, txFlagM, busyM, doneM, okM, errM, tmoM;
   logic [7:0]  txDataM;
   logic [14:0] outVecS, outVecL;

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;

   byteQ_t      txLog;
   int          pend          = 0;
   int          txDoneCnt     = 0;
   int          reqCnt        = 0;
   int          doneCnt       = 0;
   int          overlapCnt    = 0;
   int          lastTxDoneCyc = 0;
   int          doneCyc       = 0;
   logic [7:0]  payBase       = '0;

   int          txBase, txDoneBase, reqBase, doneBase, overlapBase;
   vec_t        vecs [6];

   assign startS  = start & ~useL;
   assign startL  = start & useL;
   assign rxFlagS = rx_flag & ~useL;
   assign rxFlagL = rx_flag & useL;

   frame_gen #(.ACK_TIMEOUT(100), .CNT_W(32)) dutS (
      .sclk(sclk), .rst(rst), .start(startS), .cmd_erase(cmd_erase),
      .addr(addr), .len(len), .data_req(dataReqS), .data_in(data_in),
      .tx_data(txDataS), .tx_flag(txFlagS), .tx_done(tx_done),
      .rx_data(rx_data), .rx_flag(rxFlagS), .busy(busyS), .done(doneS),
      .ack_ok(okS), .ack_err(errS), .ack_tmo(tmoS)
   );

   frame_gen #(.ACK_TIMEOUT(2000), .CNT_W(32)) dutL (
      .sclk(sclk), .rst(rst), .start(startL), .cmd_erase(cmd_erase),
      .addr(addr), .len(len), .data_req(dataReqL), .data_in(data_in),
      .tx_data(txDataL), .tx_flag(txFlagL), .tx_done(tx_done),
      .rx_data(rx_data), .rx_flag(rxFlagL), .busy(busyL), .done(doneL),
      .ack_ok(okL), .ack_err(errL), .ack_tmo(tmoL)
   );

   assign dataReqM = useL ? dataReqL : dataReqS;
   assign txFlagM  = useL ? txFlagL  : txFlagS;
   assign txDataM  = useL ? txDataL  : txDataS;
   assign busyM    = useL ? busyL    : busyS;
   assign doneM    = useL ? doneL    : doneS;
   assign okM      = useL ? okL      : okS;
   assign errM     = useL ? errL     : errS;
   assign tmoM     = useL ? tmoL     : tmoS;
   assign outVecS  = {dataReqS, txDataS, txFlagS, busyS, doneS, okS, errS, tmoS};
   assign outVecL  = {dataReqL, txDataL, txFlagL, busyL, doneL, okL, errL, tmoL};

   always #5 sclk = ~sclk;

   always @(posedge sclk) cyc++;

   // UART transmitter and payload source model, sampled on the falling edge:
   // logs every strobed byte, answers with tx_done 10 cycles later and
   // presents the next payload byte in the cycle after each data_req.
   always @(negedge sclk) begin
      if (rst) begin
         tx_done = 1'b0;
         pend    = 0;
      end else begin
         tx_done = 1'b0;
         if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
               tx_done       = 1'b1;
               txDoneCnt     = txDoneCnt + 1;
               lastTxDoneCyc = cyc;
            end
         end
         if (txFlagM) begin
            if (pend > 0) overlapCnt = overlapCnt + 1;
            txLog.push_back(txDataM);
            pend = 10;
         end
         if (dataReqM) begin
            data_in = payBase + 8'(reqCnt - reqBase);
            reqCnt  = reqCnt + 1;
         end
         if (doneM) begin
            doneCnt = doneCnt + 1;
            doneCyc = cyc;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
      end
   endtask

   function automatic byteQ_t buildExpected(input vec_t v);
      byteQ_t q;
      for (int i = 0; i < 7; i++) q.push_back(8'h55);
      q.push_back(8'hD5);
      q.push_back(v.erase ? 8'h55 : 8'hAA);
      q.push_back(v.addr[23:16]);
      q.push_back(v.addr[15:8]);
      q.push_back(v.addr[7:0]);
      if (!v.erase) begin
         for (int i = 0; i < int'(v.len); i++) q.push_back(v.payBase + 8'(i));
      end
      return q;
   endfunction

   task automatic startFrame(input vec_t v);
      @(negedge sclk); #1;
      useL        = v.useL;
      payBase     = v.payBase;
      txBase      = txLog.size();
      txDoneBase  = txDoneCnt;
      reqBase     = reqCnt;
      doneBase    = doneCnt;
      overlapBase = overlapCnt;
      cmd_erase   = v.erase;
      addr        = v.addr;
      len         = v.len;
      start       = 1'b1;
      @(negedge sclk); #1;
      start = 1'b0;
      checkOutput("busyAfterStart", 32'(busyM), 32'd1);
      checkOutput("statusClearedAtStart", 32'({okM, errM, tmoM}), 32'd0);
   endtask

   task automatic applyStimulus(input vec_t v);
      int ackCnt;
      bit acked;
      bit restarted;
      int expN;
      ackCnt    = 0;
      acked     = 1'b0;
      restarted = 1'b0;
      expN      = buildExpected(v).size();
      startFrame(v);
      for (int c = 0; c < 6000; c++) begin
         @(negedge sclk); #1;
         rx_flag = 1'b0;
         start   = 1'b0;
         if (doneCnt != doneBase) break;
         if (v.restartAt != 0 && !restarted && (txLog.size() - txBase) >= v.restartAt) begin
            start     = 1'b1;
            restarted = 1'b1;
         end
         if (v.rxEn && !acked && (txDoneCnt - txDoneBase) >= expN) begin
            ackCnt++;
            if (ackCnt >= v.ackDelay) begin
               rx_flag = 1'b1;
               rx_data = v.ackByte;
               acked   = 1'b1;
            end
         end
      end
      rx_flag = 1'b0;
      start   = 1'b0;
      repeat (5) @(negedge sclk);
      #1;
   endtask

   task automatic checkFrame(input vec_t v, input int k);
      byteQ_t exp;
      int     got;
      int     n;
      exp = buildExpected(v);
      got = txLog.size() - txBase;
      checkOutput($sformatf("f%0d byteCount", k), 32'(got), 32'(exp.size()));
      n = (got < exp.size()) ? got : exp.size();
      for (int i = 0; i < n; i++)
         checkOutput($sformatf("f%0d byte%0d", k, i), 32'(txLog[txBase + i]), 32'(exp[i]));
      checkOutput($sformatf("f%0d dataReqCount", k), 32'(reqCnt - reqBase), 32'(v.expReq));
      checkOutput($sformatf("f%0d doneCount", k), 32'(doneCnt - doneBase), 32'd1);
      checkOutput($sformatf("f%0d status{ok,err,tmo}", k), 32'({okM, errM, tmoM}), 32'(v.expStat));
      checkOutput($sformatf("f%0d busyAtEnd", k), 32'(busyM), 32'd0);
      checkOutput($sformatf("f%0d overlappingBytes", k), 32'(overlapCnt - overlapBase), 32'd0);
      if (v.expGap != 0)
         checkOutput($sformatf("f%0d txDoneToDoneCycles", k), 32'(doneCyc - lastTxDoneCyc), 32'(v.expGap));
   endtask

   initial begin
      vec_t rv;
      int   cnt;
      int   snap;

      //            useL  erase addr        len    payB   rxEn delay ack    rstrt stat    req gap
      vecs[0] = '{1'b0, 1'b0, 24'h123456, 16'd3, 8'h01, 1'b1, 5,    8'hAA, 0,    3'b100, 3,  0};
      vecs[1] = '{1'b1, 1'b1, 24'h0F0000, 16'd5, 8'h00, 1'b1, 1000, 8'h55, 0,    3'b100, 0,  0};
      vecs[2] = '{1'b0, 1'b0, 24'h00C0DE, 16'd2, 8'hA0, 1'b0, 1,    8'h00, 0,    3'b001, 2,  100};
      vecs[3] = '{1'b0, 1'b0, 24'h765432, 16'd1, 8'h3C, 1'b1, 4,    8'h55, 3,    3'b010, 1,  0};
      vecs[4] = '{1'b0, 1'b0, 24'hABCDEF, 16'd0, 8'h00, 1'b1, 7,    8'hAA, 0,    3'b100, 0,  0};
      vecs[5] = '{1'b0, 1'b1, 24'h00AB00, 16'd9, 8'h00, 1'b1, 3,    8'hAA, 0,    3'b010, 0,  0};
      rv      = '{1'b0, 1'b0, 24'h00FF80, 16'd2, 8'h80, 1'b1, 2,    8'hAA, 0,    3'b100, 2,  0};

      $display("[TB] reset state");
      repeat (3) @(negedge sclk);
      #1;
      checkOutput("resetOutputsS", 32'(outVecS), 32'd0);
      checkOutput("resetOutputsL", 32'(outVecL), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge sclk);

      for (int k = 0; k < 6; k++) begin
         $display("[TB] frame %0d", k);
         applyStimulus(vecs[k]);
         checkFrame(vecs[k], k);
      end

      $display("[TB] reset during address byte wait");
      startFrame(rv);
      cnt = 0;
      for (int c = 0; c < 500; c++) begin
         @(negedge sclk); #1;
         cnt = txLog.size() - txBase;
         if (cnt >= 10) break;
      end
      checkOutput("reachedAddrByte", 32'(cnt >= 10), 32'd1);
      repeat (3) @(negedge sclk);
      #1;
      rst = 1'b1;
      @(negedge sclk); #1;
      checkOutput("midFrameResetOutputs", 32'(outVecS), 32'd0);
      repeat (2) @(negedge sclk);
      #1;
      rst  = 1'b0;
      snap = txLog.size();
      repeat (20) @(negedge sclk);
      #1;
      checkOutput("noTxAfterReset", 32'(txLog.size() - snap), 32'd0);
      checkOutput("idleAfterReset", 32'(busyS), 32'd0);

      $display("[TB] fresh frame after reset");
      applyStimulus(rv);
      checkFrame(rv, 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
